// File: rtl/serial_add_pkg.sv
// Shared definitions for the serial adder: state encoding, slice width and
// the default operand width.
package serial_add_pkg;

   localparam int SLICE_W       = 2;
   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : serial_add_pkg

// File: rtl/add2_slice.sv
// Purely combinational 2-bit ripple-carry full adder; the only arithmetic
// hardware in the serial adder, reused once per slice of the operands.
module add2_slice
   import serial_add_pkg::*;
(
   input  logic [SLICE_W-1:0] x,
   input  logic [SLICE_W-1:0] y,
   input  logic               ci,
   output logic [SLICE_W-1:0] s,
   output logic               co
);

   // carry[gi] is the carry into bit gi; carry[SLICE_W] leaves the slice
   logic [SLICE_W:0] carry;

   assign carry[0] = ci;

   // One full-adder cell per bit, rippling the carry upward
   for (genvar gi = 0; gi < SLICE_W; gi++) begin : g_fa
      assign s[gi]       = x[gi] ^ y[gi] ^ carry[gi];
      assign carry[gi+1] = (x[gi] & y[gi]) | (carry[gi] & (x[gi] ^ y[gi]));
   end

   assign co = carry[SLICE_W];

endmodule : add2_slice

// File: rtl/serial_add_ctrl.sv
// Serial adder controller: accepts two WIDTH-bit operands over a valid/ready
// handshake, adds them 2 bits per cycle through a single add2_slice, and
// presents the result over a second valid/ready handshake.
// Optional build macro SERIAL_ADD_SUB_EN: when defined, sub=1 at the accepting
// edge turns the operation into a-b (cout=1 means no borrow); when undefined
// the sub input is ignored and the block always adds.
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = $clog2(WIDTH / 2) + 1
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   // Operands are consumed in whole slices, so the width must be a
   // positive multiple of the slice width
   if ((WIDTH < SLICE_W) || ((WIDTH % SLICE_W) != 0)) begin : g_bad_width
      $error("serial_add_ctrl: WIDTH must be even and >= 2");
   end

   state_t             state_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [WIDTH-1:0]   sum_q;       // partial sum, filled from the MSB end
   logic [WIDTH-1:0]   sum_out_q;   // last completed result, held for the sink
   logic               carry_q;
   logic               cout_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               in_ready_q;
   logic               out_valid_q;
   logic               busy_q;

   logic [SLICE_W-1:0]       slice_s;
   logic                     slice_co;
   logic [WIDTH+SLICE_W-1:0] sum_cat_d;
   logic [WIDTH-1:0]         sum_d;
   logic                     last_slice_d;
   logic [WIDTH-1:0]         b_load_d;
   logic                     carry_load_d;

   // The shared slice always works on the low bits of the shifting operands
   add2_slice u_slice (
      .x  (a_q[SLICE_W-1:0]),
      .y  (b_q[SLICE_W-1:0]),
      .ci (carry_q),
      .s  (slice_s),
      .co (slice_co)
   );

   // Next partial sum and end-of-operation detect; the concatenate-then-slice
   // form stays legal even when WIDTH equals the slice width
   always_comb begin
      sum_cat_d    = {slice_s, sum_q};
      sum_d        = sum_cat_d[WIDTH+SLICE_W-1:SLICE_W];
      last_slice_d = (cnt_q == CNT_W'(WIDTH / SLICE_W - 1));
   end

`ifdef SERIAL_ADD_SUB_EN
   // Subtraction is a + ~b + 1, so only the loaded B and carry change
   always_comb begin
      b_load_d     = sub ? ~b : b;
      carry_load_d = sub ? 1'b1 : cin;
   end
`else
   // sub is kept on the interface but has no effect in add-only builds
   logic unused_sub;
   assign unused_sub = sub;

   // Plain addition: operands and carry load unchanged
   always_comb begin
      b_load_d     = b;
      carry_load_d = cin;
   end
`endif

   // Controller FSM with datapath registers and registered handshake outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         sum_out_q   <= '0;
         carry_q     <= 1'b0;
         cout_q      <= 1'b0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid && in_ready_q) begin
                  a_q        <= a;
                  b_q        <= b_load_d;
                  carry_q    <= carry_load_d;
                  sum_q      <= '0;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= RUN;
               end
            end
            RUN: begin
               a_q     <= a_q >> SLICE_W;
               b_q     <= b_q >> SLICE_W;
               carry_q <= slice_co;
               sum_q   <= sum_d;
               cnt_q   <= cnt_q + CNT_W'(1);
               if (last_slice_d) begin
                  sum_out_q   <= sum_d;
                  cout_q      <= slice_co;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign sum       = sum_out_q;
   assign cout      = cout_q;

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// Randomized self-checking bench for serial_add_ctrl (WIDTH=8). Expected
// results come from plain integer arithmetic on the operands.
module tb_serial_add_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         sub = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] sum;
   logic         cout;
   logic         busy;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // operands presented right after an accept when in_valid is kept high
   logic [W-1:0] nxt_a, nxt_b;
   logic         nxt_c, nxt_s;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference result {cout, sum} from integer arithmetic
   function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                        input logic mc, input logic ms);
      int unsigned r;
`ifdef SERIAL_ADD_SUB_EN
      if (ms) begin
         // a - b + 2^W: bit W set exactly when no borrow occurred
         r = int'(ma) + (1 << W) - int'(mb);
         return r[W:0];
      end
`else
      if (ms) begin
         r = 0; // sub has no effect in add-only builds
      end
`endif
      r = int'(ma) + int'(mb) + int'(mc);
      return r[W:0];
   endfunction

   // One complete transaction: handshake in, wait for result, optional
   // backpressure, handshake out
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_b,
                         input logic tc, input logic ts, input int hold,
                         input bit keep_valid,
                         output int acc_cyc, output int ret_cyc);
      logic [W:0]   exp;
      logic [W-1:0] s0;
      logic         c0;
      int           n;
      exp       = model(ta, tb_b, tc, ts);
      a         = ta;
      b         = tb_b;
      cin       = tc;
      sub       = ts;
      in_valid  = 1'b1;
      out_ready = (hold == 0);
      n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
      tick();
      acc_cyc = cyc;
      if (keep_valid) begin
         a   = nxt_a;
         b   = nxt_b;
         cin = nxt_c;
         sub = nxt_s;
      end else begin
         in_valid = 1'b0;
         a        = W'($urandom);
         b        = W'($urandom);
         cin      = 1'($urandom);
         sub      = 1'($urandom);
      end
      check("busy_run", busy, 1);
      check("in_ready_run", in_ready, 0);
      n = 0;
      while (!out_valid && n < 50) begin
         check("in_ready_wait", in_ready, 0);
         tick();
         n++;
      end
      check("latency", n, W / 2);
      check("sum", sum, exp[W-1:0]);
      check("cout", cout, exp[W]);
      s0 = sum;
      c0 = cout;
      for (int i = 0; i < hold; i++) begin
         tick();
         check("bp_valid", out_valid, 1);
         check("bp_in_ready", in_ready, 0);
         check("bp_sum", sum, s0);
         check("bp_cout", cout, c0);
      end
      out_ready = 1'b1;
      tick();
      ret_cyc = cyc;
      check("retired", out_valid, 0);
      check("in_ready_after", in_ready, 1);
      check("busy_after", busy, 0);
      check("hold_sum", sum, exp[W-1:0]);
      check("hold_cout", cout, exp[W]);
      $display("op a=%02h b=%02h cin=%0d sub=%0d hold=%0d -> sum=%02h cout=%0d exp=%02h/%0d",
               ta, tb_b, tc, ts, hold, s0, c0, exp[W-1:0], exp[W]);
   endtask

   initial begin
      int acc1, ret1, acc2, ret2, n;
      bit seen;
      logic [W-1:0] ra, rb;

      // Reset state
      #2 rst = 1'b1;
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_sum", sum, 0);
      check("rst_cout", cout, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      tick();

      // Directed cases
      run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 0, 1'b0, acc1, ret1);
      run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0, 1'b0, acc1, ret1);
      run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 0, 1'b0, acc1, ret1);

      // Backpressure: five cycles of out_ready low in DONE
      run_op(8'h81, 8'h7E, 1'b1, 1'b0, 5, 1'b0, acc1, ret1);

      // Reset at RUN cycle 2 aborts the operation
      a = 8'h33; b = 8'h44; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin tick(); n++; end
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      check("abort_in_ready", in_ready, 1);
      check("abort_sum", sum, 0);
      check("abort_cout", cout, 0);
      check("abort_busy", busy, 0);
      tick();
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (out_valid) seen = 1'b1;
      end
      check("abort_no_valid", seen, 0);
      $display("abort a=33 b=44 -> no result emitted");
      run_op(8'h01, 8'h01, 1'b0, 1'b0, 0, 1'b0, acc1, ret1);

      // Back-to-back with in_valid held high
      nxt_a = 8'hC3; nxt_b = 8'h5D; nxt_c = 1'b1; nxt_s = 1'b0;
      run_op(8'h12, 8'h34, 1'b0, 1'b0, 0, 1'b1, acc1, ret1);
      run_op(nxt_a, nxt_b, nxt_c, nxt_s, 0, 1'b0, acc2, ret2);
      check("b2b_busy_span", ret1 - acc1, W / 2 + 1);
      check("b2b_reaccept_gap", acc2 - ret1, 1);
      $display("b2b accept1=%0d retire1=%0d accept2=%0d", acc1, ret1, acc2);

      // Subtract requests (effective only when the feature is built in)
      run_op(8'h10, 8'h01, 1'b0, 1'b1, 0, 1'b0, acc1, ret1);
      run_op(8'h01, 8'h02, 1'b0, 1'b1, 0, 1'b0, acc1, ret1);

      // Randomized operations
      for (int i = 0; i < 24; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         run_op(ra, rb, 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                1'b0, acc1, ret1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_serial_add_ctrl
